// File: rtl/stack_exec_unit_if.sv
// -----------------------------------------------------------------------------
// stack_exec_unit_if
// Instruction handshake between the fetch side and stack_exec_unit.
//   instr_valid : fetch side holds a valid instruction on instr
//   instr_ready : execution unit can accept; a transfer happens when both are 1
//   instr       : [31:26] opcode, [15:0] immediate, [25:16] unused
// Modports: master = fetch side (drives valid/instr), slave = execution unit.
// -----------------------------------------------------------------------------
interface stack_exec_unit_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;

    modport master (output instr_valid, output instr, input instr_ready);
    modport slave  (input instr_valid, input instr, output instr_ready);
endinterface

// File: rtl/stack_exec_unit.sv
// -----------------------------------------------------------------------------
// stack_exec_unit
// Data-stack execution engine. Accepts one stack instruction per cycle over the
// if_instr handshake and executes it against an internal DEPTH x DATA_W stack.
// Overflow, underflow and illegal opcodes put the unit into a sticky FAULT state
// that only i_fault_clr (or reset) leaves.
//
// Build option: define STACK_SAT_EN to make ADD/SUB signed-saturating; with the
// macro undefined ADD/SUB wrap modulo 2^DATA_W.
//
// Ports:
//   i_clock      system clock, rising edge
//   i_reset      synchronous active-high reset
//   if_instr     slave side of the instruction handshake (valid/ready/instr)
//   i_fault_clr  leave FAULT; ignored while running
//   o_tos        top of stack (0 when empty)
//   o_nos        next on stack (0 when fewer than two entries)
//   o_depth      entry count 0..DEPTH
//   o_empty      depth == 0
//   o_full       depth == DEPTH
//   o_done       one-cycle pulse per instruction retired without fault
//   o_fault      high while in FAULT
//   o_fault_code 1 overflow, 2 underflow, 3 illegal; held until cleared
// -----------------------------------------------------------------------------
module stack_exec_unit #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    stack_exec_unit_if.slave         if_instr,
    input  logic                     i_fault_clr,
    output logic signed [DATA_W-1:0] o_tos,
    output logic signed [DATA_W-1:0] o_nos,
    output logic [CNT_W-1:0]         o_depth,
    output logic                     o_empty,
    output logic                     o_full,
    output logic                     o_done,
    output logic                     o_fault,
    output logic [1:0]               o_fault_code
);

    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [5:0] OP_NOP  = 6'h00;
    localparam logic [5:0] OP_PUSH = 6'h01;
    localparam logic [5:0] OP_ADD  = 6'h02;
    localparam logic [5:0] OP_POP  = 6'h03;
    localparam logic [5:0] OP_SUB  = 6'h04;
    localparam logic [5:0] OP_DUP  = 6'h05;
    localparam logic [5:0] OP_SWAP = 6'h06;

    localparam logic [1:0] FC_NONE = 2'd0;
    localparam logic [1:0] FC_OVF  = 2'd1;
    localparam logic [1:0] FC_UNF  = 2'd2;
    localparam logic [1:0] FC_ILL  = 2'd3;

    typedef enum logic {ST_RUN, ST_FAULT} state_t;

`ifdef STACK_SAT_EN
    // b op a computed one bit wider; a disagreement between the two top bits
    // means the signed result left the representable range.
    function automatic logic signed [DATA_W-1:0] sat_addsub(
        input logic signed [DATA_W-1:0] b,
        input logic signed [DATA_W-1:0] a,
        input logic                     sub
    );
        logic signed [DATA_W:0] s;
        s = sub ? ($signed({b[DATA_W-1], b}) - $signed({a[DATA_W-1], a}))
                : ($signed({b[DATA_W-1], b}) + $signed({a[DATA_W-1], a}));
        if (s[DATA_W] != s[DATA_W-1])
            sat_addsub = s[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                                   : {1'b0, {(DATA_W-1){1'b1}}};
        else
            sat_addsub = s[DATA_W-1:0];
    endfunction
`endif

    // Control state (reset)
    state_t            r_state;
    logic [CNT_W-1:0]  r_depth;
    logic              r_done;
    logic [1:0]        r_fault_code;

    // Stack storage (data, not reset: depth==0 masks stale contents)
    logic signed [DATA_W-1:0] r_stack [DEPTH];

    state_t                   w_state_nxt;
    logic [CNT_W-1:0]         w_depth_nxt;
    logic                     w_done_nxt;
    logic [1:0]               w_code_nxt;
    logic [5:0]               w_op;
    logic signed [31:0]       w_imm32;
    logic signed [DATA_W-1:0] w_imm;
    logic signed [DATA_W-1:0] w_a;
    logic signed [DATA_W-1:0] w_b;
    logic signed [DATA_W-1:0] w_arith;
    logic [PTR_W-1:0]         w_idx_a;
    logic [PTR_W-1:0]         w_idx_b;
    logic [PTR_W-1:0]         w_idx_push;
    logic                     w_accept;
    logic                     w_illegal;
    logic                     w_ovf;
    logic                     w_unf;
    logic                     w_err;
    logic                     w_commit;
    logic                     w_we0;
    logic [PTR_W-1:0]         w_idx0;
    logic signed [DATA_W-1:0] w_dat0;
    logic                     w_we1;
    logic [PTR_W-1:0]         w_idx1;
    logic signed [DATA_W-1:0] w_dat1;
    logic                     w_unused_bits;

    assign w_op          = if_instr.instr[31:26];
    assign w_unused_bits = ^if_instr.instr[25:16];
    assign w_imm32       = 32'($signed(if_instr.instr[15:0]));
    assign w_imm         = DATA_W'(w_imm32);

    // Pointer arithmetic truncates to the array index width; out-of-range
    // values only occur when the corresponding error check blocks the access.
    assign w_idx_a    = PTR_W'(r_depth - CNT_W'(1));
    assign w_idx_b    = PTR_W'(r_depth - CNT_W'(2));
    assign w_idx_push = PTR_W'(r_depth);
    assign w_a        = r_stack[w_idx_a];
    assign w_b        = r_stack[w_idx_b];

    assign w_accept  = if_instr.instr_valid && (r_state == ST_RUN);
    assign w_illegal = (w_op > OP_SWAP);
    assign w_ovf     = ((w_op == OP_PUSH) || (w_op == OP_DUP)) && (r_depth == CNT_W'(DEPTH));
    assign w_unf     = (((w_op == OP_ADD) || (w_op == OP_SUB) || (w_op == OP_SWAP)) && (r_depth < CNT_W'(2)))
                    || (((w_op == OP_POP) || (w_op == OP_DUP)) && (r_depth == '0));
    assign w_err     = w_illegal || w_ovf || w_unf;
    assign w_commit  = w_accept && !w_err;

`ifdef STACK_SAT_EN
    assign w_arith = sat_addsub(w_b, w_a, w_op == OP_SUB);
`else
    assign w_arith = (w_op == OP_SUB) ? (w_b - w_a) : (w_b + w_a);
`endif

    // Datapath: stack write ports and depth update for a retiring instruction
    always_comb begin
        w_we0       = 1'b0;
        w_idx0      = w_idx_push;
        w_dat0      = w_imm;
        w_we1       = 1'b0;
        w_idx1      = w_idx_b;
        w_dat1      = w_a;
        w_depth_nxt = r_depth;
        if (w_commit) begin
            case (w_op)
                OP_PUSH: begin
                    w_we0       = 1'b1;
                    w_depth_nxt = r_depth + CNT_W'(1);
                end
                OP_ADD, OP_SUB: begin
                    w_we0       = 1'b1;
                    w_idx0      = w_idx_b;
                    w_dat0      = w_arith;
                    w_depth_nxt = r_depth - CNT_W'(1);
                end
                OP_POP: w_depth_nxt = r_depth - CNT_W'(1);
                OP_DUP: begin
                    w_we0       = 1'b1;
                    w_dat0      = w_a;
                    w_depth_nxt = r_depth + CNT_W'(1);
                end
                OP_SWAP: begin
                    w_we0  = 1'b1;
                    w_idx0 = w_idx_a;
                    w_dat0 = w_b;
                    w_we1  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // FSM next state, fault code and retire pulse
    always_comb begin
        w_state_nxt = r_state;
        w_code_nxt  = r_fault_code;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_accept) begin
                    if (w_err) begin
                        w_state_nxt = ST_FAULT;
                        w_code_nxt  = w_illegal ? FC_ILL : (w_ovf ? FC_OVF : FC_UNF);
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
            end
            ST_FAULT: begin
                if (i_fault_clr) begin
                    w_state_nxt = ST_RUN;
                    w_code_nxt  = FC_NONE;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // Stage boundary: control registers
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= ST_RUN;
            r_depth      <= '0;
            r_done       <= 1'b0;
            r_fault_code <= FC_NONE;
        end else begin
            r_state      <= w_state_nxt;
            r_depth      <= w_depth_nxt;
            r_done       <= w_done_nxt;
            r_fault_code <= w_code_nxt;
        end
    end

    // Stage boundary: stack storage
    always_ff @(posedge i_clock) begin
        if (w_we0) r_stack[w_idx0] <= w_dat0;
        if (w_we1) r_stack[w_idx1] <= w_dat1;
    end

    assign if_instr.instr_ready = (r_state == ST_RUN);
    assign o_tos        = (r_depth == '0) ? '0 : w_a;
    assign o_nos        = (r_depth < CNT_W'(2)) ? '0 : w_b;
    assign o_depth      = r_depth;
    assign o_empty      = (r_depth == '0);
    assign o_full       = (r_depth == CNT_W'(DEPTH));
    assign o_done       = r_done;
    assign o_fault      = (r_state == ST_FAULT);
    assign o_fault_code = r_fault_code;

endmodule

// File: tb/tb_stack_exec_unit.sv
// -----------------------------------------------------------------------------
// tb_stack_exec_unit
// Two instances share one stimulus stream: A (DATA_W=32, DEPTH=16) and
// B (DATA_W=8, DEPTH=4). A queue-based reference model per instance predicts
// every visible output; directed scenarios add constant expectations.
// -----------------------------------------------------------------------------
module tb_stack_exec_unit;

    logic clk;
    logic rst;
    logic fclr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    stack_exec_unit_if ifa ();
    stack_exec_unit_if ifb ();

    logic [31:0] a_tos, a_nos;
    logic [4:0]  a_depth;
    logic        a_empty, a_full, a_done, a_fault;
    logic [1:0]  a_code;
    logic [7:0]  b_tos, b_nos;
    logic [2:0]  b_depth;
    logic        b_empty, b_full, b_done, b_fault;
    logic [1:0]  b_code;

    stack_exec_unit #(.DATA_W(32), .DEPTH(16)) dut_a (
        .i_clock(clk), .i_reset(rst), .if_instr(ifa), .i_fault_clr(fclr),
        .o_tos(a_tos), .o_nos(a_nos), .o_depth(a_depth), .o_empty(a_empty),
        .o_full(a_full), .o_done(a_done), .o_fault(a_fault), .o_fault_code(a_code)
    );

    stack_exec_unit #(.DATA_W(8), .DEPTH(4)) dut_b (
        .i_clock(clk), .i_reset(rst), .if_instr(ifb), .i_fault_clr(fclr),
        .o_tos(b_tos), .o_nos(b_nos), .o_depth(b_depth), .o_empty(b_empty),
        .o_full(b_full), .o_done(b_done), .o_fault(b_fault), .o_fault_code(b_code)
    );

    logic [75:0] act_a;
    logic [25:0] act_b;
    assign act_a = {a_tos, a_nos, a_depth, a_empty, a_full, a_done, a_fault, a_code, ifa.instr_ready};
    assign act_b = {b_tos, b_nos, b_depth, b_empty, b_full, b_done, b_fault, b_code, ifb.instr_ready};

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: stacks as queues (top = back), plus flags.
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    bit          m_done  [2];
    bit          m_fault [2];
    logic [1:0]  m_code  [2];

    function automatic logic [31:0] mk(input int op, input int imm);
        mk = {6'(op), 10'd0, 16'(imm)};
    endfunction

    task automatic model_step(input int k, input bit v, input logic [31:0] ins,
                              input bit clr, input bit r);
        logic [31:0] q[$];
        int          w, d, n, code;
        logic [5:0]  op;
        longint      a, b, res, msk, half;
        if (k == 0) begin q = q0; w = 32; d = 16; end
        else        begin q = q1; w = 8;  d = 4;  end
        msk  = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        m_done[k] = 1'b0;
        if (r) begin
            q.delete();
            m_fault[k] = 1'b0;
            m_code[k]  = 2'd0;
        end else if (m_fault[k]) begin
            if (clr) begin
                m_fault[k] = 1'b0;
                m_code[k]  = 2'd0;
            end
        end else if (v) begin
            op   = ins[31:26];
            n    = q.size();
            code = 0;
            if (op > 6) code = 3;
            else if ((op == 1 || op == 5) && n == d) code = 1;
            else if (((op == 2 || op == 4 || op == 6) && n < 2) || ((op == 3 || op == 5) && n < 1)) code = 2;
            if (code != 0) begin
                m_fault[k] = 1'b1;
                m_code[k]  = 2'(code);
            end else begin
                m_done[k] = 1'b1;
                case (op)
                    1: q.push_back(32'(longint'($signed(ins[15:0])) & msk));
                    2, 4: begin
                        a = q.pop_back();
                        b = q.pop_back();
`ifdef STACK_SAT_EN
                        if (a >= half) a = a - 2 * half;
                        if (b >= half) b = b - 2 * half;
                        res = (op == 2) ? b + a : b - a;
                        if (res > half - 1) res = half - 1;
                        if (res < -half)    res = -half;
`else
                        res = (op == 2) ? b + a : b - a;
`endif
                        q.push_back(32'(res & msk));
                    end
                    3: void'(q.pop_back());
                    5: q.push_back(q[n-1]);
                    6: begin
                        a = q.pop_back();
                        b = q.pop_back();
                        q.push_back(32'(a));
                        q.push_back(32'(b));
                    end
                    default: ;
                endcase
            end
        end
        if (k == 0) q0 = q; else q1 = q;
    endtask

    function automatic logic [75:0] exp_a();
        int n;
        logic [31:0] t, s;
        n = q0.size(); t = '0; s = '0;
        if (n > 0) t = q0[n-1];
        if (n > 1) s = q0[n-2];
        exp_a = {t, s, 5'(n), (n == 0), (n == 16), m_done[0], m_fault[0], m_code[0], ~m_fault[0]};
    endfunction

    function automatic logic [25:0] exp_b();
        int n;
        logic [7:0] t, s;
        n = q1.size(); t = '0; s = '0;
        if (n > 0) t = 8'(q1[n-1]);
        if (n > 1) s = 8'(q1[n-2]);
        exp_b = {t, s, 3'(n), (n == 0), (n == 4), m_done[1], m_fault[1], m_code[1], ~m_fault[1]};
    endfunction

    // Applies one cycle of inputs to both instances (called just after negedge),
    // advances the models at the edge and returns at the following negedge.
    task automatic drive(input bit v, input logic [31:0] ins, input bit clr, input bit r);
        ifa.instr_valid = v; ifb.instr_valid = v;
        ifa.instr = ins;     ifb.instr = ins;
        fclr = clr; rst = r;
        @(posedge clk);
        model_step(0, v, ins, clr, r);
        model_step(1, v, ins, clr, r);
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(1'b1, mk(1, 16'h1234), 1'b1, 1'b1);
        n_cmp++;
        if ({a_tos, a_nos, a_depth, a_done, a_fault, a_code, ifa.instr_ready} !==
            {32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 2'd0, 1'b1}) begin
            n_bad++;
            $display("FAIL reset_a act=%h", act_a);
        end
        n_cmp++;
        if (act_b !== exp_b()) begin
            n_bad++; $display("FAIL reset_b act=%h exp=%h", act_b, exp_b());
        end
    endtask

    task automatic test_t1_sequence();
        logic [31:0] pv [5] = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};
        logic [31:0] ev [3] = '{32'h77, 32'h99, 32'hAA};
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        foreach (pv[i]) drive(1'b1, mk(1, int'(pv[i])), 1'b0, 1'b0);
        drive(1'b1, mk(0, 0), 1'b0, 1'b0);
        drive(1'b1, mk(3, 0), 1'b0, 1'b0);
        n_cmp++;
        if (a_tos !== 32'h44 || a_depth !== 5'd4) begin
            n_bad++; $display("FAIL t1_pop tos=%h depth=%0d want 44/4", a_tos, a_depth);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, mk(2, 0), 1'b0, 1'b0);
            n_cmp++;
            if (a_tos !== ev[i] || a_depth !== 5'(3 - i) || a_done !== 1'b1) begin
                n_bad++; $display("FAIL t1_add%0d tos=%h depth=%0d want %h/%0d", i, a_tos, a_depth, ev[i], 3 - i);
            end
        end
        drive(1'b1, mk(2, 0), 1'b0, 1'b0);
        n_cmp++;
        if ({a_fault, a_code, a_depth, a_tos, a_done} !== {1'b1, 2'd2, 5'd1, 32'hAA, 1'b0}) begin
            n_bad++; $display("FAIL t1_unf fault=%b code=%0d depth=%0d tos=%h want 1/2/1/aa", a_fault, a_code, a_depth, a_tos);
        end
        n_cmp++;
        if (act_b !== exp_b()) begin
            n_bad++; $display("FAIL t1_model_b act=%h exp=%h", act_b, exp_b());
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_t2_overflow();
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 1; i <= 4; i++) drive(1'b1, mk(1, i), 1'b0, 1'b0);
        n_cmp++;
        if (b_full !== 1'b1 || b_depth !== 3'd4) begin
            n_bad++; $display("FAIL t2_full full=%b depth=%0d want 1/4", b_full, b_depth);
        end
        drive(1'b1, mk(1, 5), 1'b0, 1'b0);
        n_cmp++;
        if ({b_code, b_tos, ifb.instr_ready, b_full} !== {2'd1, 8'd4, 1'b0, 1'b1}) begin
            n_bad++; $display("FAIL t2_ovf code=%0d tos=%h ready=%b want 1/04/0", b_code, b_tos, ifb.instr_ready);
        end
        // In FAULT a valid POP must not be taken.
        drive(1'b1, mk(3, 0), 1'b0, 1'b0);
        n_cmp++;
        if (b_depth !== 3'd4 || b_fault !== 1'b1 || b_done !== 1'b0) begin
            n_bad++; $display("FAIL t2_hold depth=%0d fault=%b want 4/1", b_depth, b_fault);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        n_cmp++;
        if ({ifb.instr_ready, b_code, b_depth, b_tos} !== {1'b1, 2'd0, 3'd4, 8'd4}) begin
            n_bad++; $display("FAIL t2_clr ready=%b code=%0d depth=%0d want 1/0/4", ifb.instr_ready, b_code, b_depth);
        end
        n_cmp++;
        if (act_a !== exp_a()) begin
            n_bad++; $display("FAIL t2_model_a act=%h exp=%h", act_a, exp_a());
        end
    endtask

    task automatic test_t3_illegal_swap_dup();
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        drive(1'b1, mk(1, 5), 1'b0, 1'b0);
        drive(1'b1, mk(1, 9), 1'b0, 1'b0);
        drive(1'b1, mk(6'h3F, 16'hFFFF), 1'b0, 1'b0);
        n_cmp++;
        if ({a_code, a_fault, a_depth, a_tos, a_nos} !== {2'd3, 1'b1, 5'd2, 32'd9, 32'd5}) begin
            n_bad++; $display("FAIL t3_illegal code=%0d depth=%0d tos=%h nos=%h want 3/2/9/5", a_code, a_depth, a_tos, a_nos);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        drive(1'b1, mk(6, 0), 1'b0, 1'b0);
        n_cmp++;
        if (a_tos !== 32'd5 || a_nos !== 32'd9 || a_done !== 1'b1) begin
            n_bad++; $display("FAIL t3_swap tos=%h nos=%h want 5/9", a_tos, a_nos);
        end
        drive(1'b1, mk(5, 0), 1'b0, 1'b0);
        n_cmp++;
        if (a_tos !== 32'd5 || a_nos !== 32'd5 || a_depth !== 5'd3) begin
            n_bad++; $display("FAIL t3_dup tos=%h nos=%h depth=%0d want 5/5/3", a_tos, a_nos, a_depth);
        end
    endtask

    task automatic test_t4_arith_width();
        logic [7:0] e_add, e_sub;
`ifdef STACK_SAT_EN
        e_add = 8'h7F; e_sub = 8'h80;
`else
        e_add = 8'h80; e_sub = 8'h7F;
`endif
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        drive(1'b1, mk(1, 16'h007F), 1'b0, 1'b0);
        drive(1'b1, mk(1, 16'h0001), 1'b0, 1'b0);
        drive(1'b1, mk(2, 0), 1'b0, 1'b0);
        n_cmp++;
        if (b_tos !== e_add || b_depth !== 3'd1 || b_fault !== 1'b0) begin
            n_bad++; $display("FAIL t4_add tos=%h want %h", b_tos, e_add);
        end
        drive(1'b1, mk(1, 16'hFF80), 1'b0, 1'b0);
        drive(1'b1, mk(1, 16'h0001), 1'b0, 1'b0);
        drive(1'b1, mk(4, 0), 1'b0, 1'b0);
        n_cmp++;
        if (b_tos !== e_sub || b_depth !== 3'd2 || b_nos !== e_add) begin
            n_bad++; $display("FAIL t4_sub tos=%h nos=%h want %h/%h", b_tos, b_nos, e_sub, e_add);
        end
        n_cmp++;
        if (a_tos !== 32'hFFFFFF7F || a_nos !== 32'h80) begin
            n_bad++; $display("FAIL t4_wide tos=%h nos=%h want ffffff7f/80", a_tos, a_nos);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] t_hold;
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, mk(1, int'($urandom_range(0, 65535))), 1'b0, 1'b0);
            n_cmp++;
            if (a_done !== 1'b1 || act_a !== exp_a()) begin
                n_bad++; $display("FAIL b2b_push%0d act=%h exp=%h", i, act_a, exp_a());
            end
        end
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        drive(1'b1, mk(1, 16'h0A), 1'b0, 1'b0);
        drive(1'b1, mk(1, 16'h0B), 1'b0, 1'b0);
        drive(1'b1, mk(1, 16'h0C), 1'b0, 1'b1);
        n_cmp++;
        if ({a_depth, a_tos, a_fault, a_done} !== {5'd0, 32'd0, 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL b2b_reset depth=%0d tos=%h fault=%b want 0/0/0", a_depth, a_tos, a_fault);
        end
        drive(1'b1, mk(1, 16'h0D), 1'b0, 1'b0);
        drive(1'b1, mk(1, 16'h0E), 1'b0, 1'b0);
        t_hold = a_tos;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, $urandom, 1'b0, 1'b0);
            n_cmp++;
            if (a_depth !== 5'd2 || a_tos !== t_hold || a_done !== 1'b0 || t_hold !== 32'h0E) begin
                n_bad++; $display("FAIL b2b_idle%0d depth=%0d tos=%h done=%b want 2/0e/0", i, a_depth, a_tos, a_done);
            end
        end
    endtask

    task automatic test_clr_with_reset();
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        drive(1'b1, mk(1, 3), 1'b0, 1'b0);
        drive(1'b1, mk(6'h20, 0), 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b1);
        n_cmp++;
        if ({a_fault, a_code, a_depth, ifa.instr_ready} !== {1'b0, 2'd0, 5'd0, 1'b1}) begin
            n_bad++; $display("FAIL clr_rst fault=%b code=%0d depth=%0d", a_fault, a_code, a_depth);
        end
        // fault_clr while running is ignored; the accompanying PUSH still executes.
        drive(1'b1, mk(1, 7), 1'b1, 1'b0);
        n_cmp++;
        if (a_depth !== 5'd1 || a_tos !== 32'd7 || a_done !== 1'b1) begin
            n_bad++; $display("FAIL clr_run depth=%0d tos=%h want 1/7", a_depth, a_tos);
        end
    endtask

    task automatic test_random();
        int op;
        bit v, c, r;
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 600; i++) begin
            op = int'($urandom_range(0, 7));
            if (op == 7 && $urandom_range(0, 3) == 0) op = int'($urandom_range(7, 63));
            else if (op == 7) op = 1;
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 59) == 0);
            drive(v, {6'(op), 10'($urandom), 16'($urandom)}, c, r);
            n_cmp++;
            if (act_a !== exp_a()) begin
                n_bad++; $display("FAIL rand_a cyc=%0d act=%h exp=%h", i, act_a, exp_a());
            end
            n_cmp++;
            if (act_b !== exp_b()) begin
                n_bad++; $display("FAIL rand_b cyc=%0d act=%h exp=%h", i, act_b, exp_b());
            end
        end
    endtask

    initial begin
        rst = 1'b1; fclr = 1'b0;
        ifa.instr_valid = 1'b0; ifb.instr_valid = 1'b0;
        ifa.instr = '0; ifb.instr = '0;
        m_done  = '{default: 1'b0};
        m_fault = '{default: 1'b0};
        m_code  = '{default: 2'd0};
        @(negedge clk);
        test_reset();
        test_t1_sequence();
        test_t2_overflow();
        test_t3_illegal_swap_dup();
        test_t4_arith_width();
        test_back_to_back();
        test_clr_with_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
